// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and twiddle index helper
// for the 16-point radix-2 DIF twiddle generator.
package fft_pkg;

  localparam int N_POINT = 16;
  localparam int LOG2N   = 4;
  localparam int TW_W    = 8;
  localparam int DATA_W  = 17;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // k = (bfly mod (8 >> stage)) << stage
  function automatic logic [2:0] tw_index(
    input logic [1:0] stage,
    input logic [2:0] bfly
  );
    logic [2:0] mask;
    mask = 3'b111 >> stage;
    return (bfly & mask) << stage;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// W16^k lookup, Q1.7, saturated so that 0x80 never appears.
// Purely combinational.
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  logic [2:0]      k,
  output logic [TW_W-1:0] re,
  output logic [TW_W-1:0] im
);

  always_comb begin
    re = 8'h7F;
    im = 8'h00;
    unique case (k)
      3'd0: begin re = 8'h7F; im = 8'h00; end
      3'd1: begin re = 8'h76; im = 8'hCF; end
      3'd2: begin re = 8'h5B; im = 8'hA5; end
      3'd3: begin re = 8'h31; im = 8'h8A; end
      3'd4: begin re = 8'h00; im = 8'h81; end
      3'd5: begin re = 8'hCF; im = 8'h8A; end
      3'd6: begin re = 8'hA5; im = 8'hA5; end
      3'd7: begin re = 8'h8A; im = 8'hCF; end
      default: begin re = 8'h7F; im = 8'h00; end
    endcase
  end

endmodule

// File: rtl/fft_twiddle_gen.sv
// Twiddle sequencer: walks stage/bfly over one 16-point FFT
// and presents registered W16^k with a valid/ready handshake.
module fft_twiddle_gen #(
  parameter int N_POINT = 16,
  parameter int TW_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            tw_ready,
  output logic [TW_W-1:0] tw_re,
  output logic [TW_W-1:0] tw_im,
  output logic            tw_valid,
  output logic [1:0]      stage,
  output logic [2:0]      bfly,
  output logic            last,
  output logic            busy
);

  import fft_pkg::*;

  localparam logic [1:0] LAST_STAGE = 2'(LOG2N - 1);
  localparam logic [2:0] LAST_BFLY  = 3'(N_POINT / 2 - 1);

  state_e          state_q;
  state_e          state_d;
  logic [1:0]      stage_d;
  logic [2:0]      bfly_d;
  logic            valid_d;
  logic            last_d;
  logic [2:0]      k_d;
  logic [TW_W-1:0] re_d;
  logic [TW_W-1:0] im_d;
  logic            accept;

  assign accept = tw_valid & tw_ready;

  always_comb begin
    state_d = state_q;
    stage_d = stage;
    bfly_d  = bfly;
    valid_d = tw_valid;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          stage_d = '0;
          bfly_d  = '0;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        // abort wins over ready; finishing item returns to IDLE
        if (abort || (accept && last)) begin
          state_d = IDLE;
          stage_d = '0;
          bfly_d  = '0;
          valid_d = 1'b0;
        end else if (accept) begin
          bfly_d = bfly + 3'd1;
          if (bfly == LAST_BFLY)
            stage_d = stage + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign k_d    = tw_index(stage_d, bfly_d);
  assign last_d = valid_d && stage_d == LAST_STAGE
               && bfly_d == LAST_BFLY;

  fft_twiddle_rom u_rom (
    .k  (k_d),
    .re (re_d),
    .im (im_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stage    <= '0;
      bfly     <= '0;
      tw_valid <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      tw_re    <= '0;
      tw_im    <= '0;
    end else begin
      state_q  <= state_d;
      stage    <= stage_d;
      bfly     <= bfly_d;
      tw_valid <= valid_d;
      last     <= last_d;
      busy     <= (state_d == RUN);
      tw_re    <= valid_d ? re_d : '0;
      tw_im    <= valid_d ? im_d : '0;
    end
  end

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Directed + randomized-ready bench for fft_twiddle_gen with
// a trig-based reference model of the twiddle sequence.
module tb_fft_twiddle_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       tw_ready;
  logic [7:0] tw_re;
  logic [7:0] tw_im;
  logic       tw_valid;
  logic [1:0] stage;
  logic [2:0] bfly;
  logic       last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  fft_twiddle_gen #(.N_POINT(16), .TW_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .tw_ready (tw_ready),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .tw_valid (tw_valid),
    .stage    (stage),
    .bfly     (bfly),
    .last     (last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] q17(input real x);
    real s;
    s = $floor(x * 128.0 + 0.5);
    if (s > 127.0) s = 127.0;
    if (s < -127.0) s = -127.0;
    return 8'($rtoi(s));
  endfunction

  // Expected {valid,busy,stage,bfly,last,re,im} for item n of 32
  function automatic logic [23:0] model(input int n);
    int   st, bf, k;
    real  ang;
    st  = n / 8;
    bf  = n % 8;
    k   = (bf % (8 >> st)) << st;
    ang = 2.0 * 3.14159265358979 * k / 16.0;
    return {1'b1, 1'b1, 2'(st), 3'(bf), n == 31,
            q17($cos(ang)), q17(-$sin(ang))};
  endfunction

  function automatic logic [23:0] obs();
    return {tw_valid, busy, stage, bfly, last, tw_re, tw_im};
  endfunction

  task automatic check(input string tag, input logic [23:0] o,
                       input logic [23:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    bit done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tw_ready = 1'b0;
    #3;
    check("reset_state", obs(), 24'h0);
    #10 rst_n = 1'b1;
    step();
    check("idle_after_reset", obs(), 24'h0);

    // Full sequence, ready held high; start asserted on last item
    tw_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("full_item%0d", i), obs(), model(i));
      if (i == 31) start = 1'b1;
      step();
      start = 1'b0;
    end
    check("full_done", obs(), 24'h0);
    step();
    check("start_on_last_ignored", obs(), 24'h0);

    // Stall at stage 1 bfly 3 with a stray start pulse
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    check("stall_pos", obs(), model(11));
    tw_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      check($sformatf("stall_hold%0d", i), obs(), model(11));
    end
    start = 1'b0;
    tw_ready = 1'b1;
    step();
    check("stall_release", obs(), model(12));
    for (int i = 12; i < 17; i++) step();
    check("abort_pos", obs(), model(17));
    abort = 1'b1;
    tw_ready = 1'b0;
    step();
    abort = 1'b0;
    check("abort_idle", obs(), 24'h0);

    // start+abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", obs(), 24'h0);

    // Restart then randomized backpressure against the model
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_item0", obs(), model(0));
    idx  = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tw_ready = 1'($urandom_range(0, 1));
      step();
      if (tw_ready) idx++;
      if (idx == 32) begin
        check("rand_done", obs(), 24'h0);
        done = 1'b1;
      end else begin
        check($sformatf("rand_item%0d", idx), obs(), model(idx));
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL rand_timeout observed=%0d expected=32", idx);
    end

    // Async reset mid-stall, then start on first edge
    tw_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    tw_ready = 1'b0;
    step();
    check("pre_reset_stall", obs(), model(4));
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 24'h0);
    #2 rst_n = 1'b1;
    start = 1'b1;
    tw_ready = 1'b1;
    step();
    start = 1'b0;
    check("start_first_edge", obs(), model(0));
    step();
    step();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    step();
    check("no_resume", obs(), 24'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
